serial_adder_ctrl: RTL and testbench

//   Bit-serial adder stage for the adder family. It accepts two WIDTH-bit

---
 rtl/serial_adder_ctrl.sv | 110 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder stage: accepts a/b over a valid/ready handshake, adds them
// LSB-first one bit per clock through a registered carry, then presents the
// sum and carry-out over a second valid/ready handshake.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   a, b                  WIDTH-bit operands, sampled on the accept edge
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   sum, cout             registered result, held until the next SHIFT
//   busy                  high in SHIFT or DONE
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Full-adder slice for the current LSB pair
    logic bit_sum;
    logic bit_carry;
    logic bit_half;

    always_comb begin
        bit_half  = shift_a[0] ^ shift_b[0];
        bit_sum   = bit_half ^ carry;
        bit_carry = (shift_a[0] & shift_b[0]) | (carry & bit_half);
    end

    // Controller, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_a   <= '0;
            shift_b   <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_a  <= a;
                        shift_b  <= b;
                        carry    <= 1'b0;
                        cnt      <= '0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Shift forms work for WIDTH=1, where a part-select would be empty
                    shift_a <= shift_a >> 1;
                    shift_b <= shift_b >> 1;
                    sum     <= (sum >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));
                    carry   <= bit_carry;
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        cout      <= bit_carry;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and back-to-back checks for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int pass_cnt  = 0;
    int check_cnt = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for IDLE, present operands for one accept edge
    task automatic accept(input logic [7:0] ta, input logic [7:0] tb_v, input string name);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check_cnt++;
        if (in_ready !== 1'b1) $display("FAIL %s_wait_idle: in_ready=%b required 1", name, in_ready);
        else pass_cnt++;
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge to out_valid, bounded
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic [8:0] exp, input string name);
        int lat;
        out_ready = 1'b1;
        accept(ta, tb_v, name);
        wait_result(lat);
        check_cnt++;
        if (lat !== 8 || out_valid !== 1'b1)
            $display("FAIL %s_latency: cycles=%0d out_valid=%b required 8/1", name, lat, out_valid);
        else pass_cnt++;
        check_cnt++;
        if ({cout, sum} !== exp)
            $display("FAIL %s_result: {cout,sum}=%h required %h", name, {cout, sum}, exp);
        else pass_cnt++;
        step();
        check_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s_back_to_idle: in_ready=%b out_valid=%b busy=%b required 1/0/0",
                     name, in_ready, out_valid, busy);
        else pass_cnt++;
        check_cnt++;
        if ({cout, sum} !== exp)
            $display("FAIL %s_hold_in_idle: {cout,sum}=%h required %h", name, {cout, sum}, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
        else pass_cnt++;
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid);
        else pass_cnt++;
        check_cnt++;
        if (sum !== 8'h00) $display("FAIL reset_sum: got %h required 00", sum);
        else pass_cnt++;
        check_cnt++;
        if (cout !== 1'b0) $display("FAIL reset_cout: got %b required 0", cout);
        else pass_cnt++;
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        do_op(8'h0F, 8'h01, 9'h010, "basic_0f_01");
    endtask

    task automatic test_carry();
        do_op(8'hFF, 8'h01, 9'h100, "carry_ff_01");
        do_op(8'hFF, 8'hFF, 9'h1FE, "carry_ff_ff");
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        accept(8'h55, 8'hAA, "bp");
        check_cnt++;
        if (in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL bp_shift_flags: in_ready=%b busy=%b required 0/1", in_ready, busy);
        else pass_cnt++;
        // Operand changes during SHIFT must not disturb the result
        in_valid = 1'b1;
        a        = 8'h01;
        b        = 8'h01;
        wait_result(lat);
        check_cnt++;
        if (lat !== 8) $display("FAIL bp_latency: cycles=%0d required 8", lat);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            check_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== 9'h0FF)
                $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b {cout,sum}=%h required 1/0/0ff",
                         i, out_valid, in_ready, {cout, sum});
            else pass_cnt++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic saw_valid;
        out_ready = 1'b1;
        accept(8'h12, 8'h34, "rmid");
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0)
            $display("FAIL rmid_abort: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b required 1/0/0/00/0",
                     in_ready, out_valid, busy, sum, cout);
        else pass_cnt++;
        @(negedge clk);
        rst_n     = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (out_valid) saw_valid = 1'b1;
        end
        check_cnt++;
        if (saw_valid !== 1'b0) $display("FAIL rmid_no_result: out_valid seen=%b required 0", saw_valid);
        else pass_cnt++;
        check_cnt++;
        if (in_ready !== 1'b1 || {cout, sum} !== 9'h000)
            $display("FAIL rmid_idle: in_ready=%b {cout,sum}=%h required 1/000", in_ready, {cout, sum});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_q[$];
        logic [8:0] exp;
        int pushed;
        int popped;
        int cyc;
        pushed    = 0;
        popped    = 0;
        cyc       = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (popped < 200 && cyc < 200 * 12 + 50) begin
            if (out_valid) begin
                check_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra_result: {cout,sum}=%h with no pending operation", {cout, sum});
                end else begin
                    exp = exp_q.pop_front();
                    if ({cout, sum} !== exp)
                        $display("FAIL b2b_result_%0d: {cout,sum}=%h required %h", popped, {cout, sum}, exp);
                    else pass_cnt++;
                end
                popped++;
            end
            if (in_ready) begin
                if (pushed < 200) begin
                    a = 8'($urandom);
                    b = 8'($urandom);
                    exp_q.push_back(9'(a) + 9'(b));
                    pushed++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check_cnt++;
        if (popped !== 200 || pushed !== 200 || exp_q.size() !== 0)
            $display("FAIL b2b_count: results=%0d accepted=%0d pending=%0d required 200/200/0",
                     popped, pushed, exp_q.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
